mem_bus_responder: RTL

Target-side endpoint of the CPU external memory bus: 24-bit byte address, re/we strobes, 16-bit bidirectional data, needWait stall.
- Decodes an address window and serves word reads/writes from an internal word array.
- Inserts a programmable number of wait states per access.
- Sits on the board/SoC side, connected directly to the CPU's addr_o/re_o/we_o/data_io/needWait_i.

---
 rtl/mem_bus_pkg.sv | 32 +++
 rtl/mem_resp_ram.sv | 45 ++++
 rtl/mem_bus_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
//
// Shared definitions for the external memory bus responder:
//   - bus widths (24-bit byte address, 16-bit data)
//   - wait-state counter width
//   - responder state encoding (IDLE, WAIT)
//   - helper to derive the wait counter reload value from WAIT_STATES
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  localparam int BUS_ADDR_W   = 24;
  localparam int BUS_DATA_W   = 16;
  localparam int WAIT_CNT_W   = 4;
  localparam int STAT_W       = 16;
  localparam int STAT_ABORT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Strobe pair as seen on the bus: {re, we}.
  typedef logic [1:0] bus_op_t;

  // The access that opens a stall already accounts for one needWait cycle,
  // so the counter is loaded with one less than the number of wait states.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wait_states);
    return (wait_states > 0) ? WAIT_CNT_W'(wait_states - 1) : '0;
  endfunction

endpackage : mem_bus_pkg

// File: rtl/mem_resp_ram.sv
// -----------------------------------------------------------------------------
// mem_resp_ram
//
// Word array behind the memory bus responder: 2^ADDR_BITS words of DATA_W
// bits, synchronous write, combinational (asynchronous) read.
//
// Ports:
//   clk    in   write clock
//   we     in   write enable, sampled on the rising edge
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  read data, combinational from raddr
// -----------------------------------------------------------------------------
module mem_resp_ram
  import mem_bus_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int DATA_W    = BUS_DATA_W
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // NOTE: the array deliberately has no reset: contents survive a bus reset,
  // and a reset on every word would prevent mapping onto RAM macros. Sequential
  // state is written with non-blocking assignments so every flop samples the
  // pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : mem_resp_ram

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
//
// Target-side endpoint of the CPU external memory bus. Decodes an address
// window of 2^(ADDR_BITS+1) bytes at BASE_ADDR and serves 16-bit word reads
// and writes from an internal array, stalling each access for WAIT_STATES
// cycles through needWait_o.
//
// Parameters:
//   ADDR_BITS    log2 of array depth in words
//   BASE_ADDR    window base, aligned to 2^(ADDR_BITS+1) bytes
//   WAIT_STATES  needWait cycles per access (0..15), 0 = single-cycle access
//
// Ports:
//   clk            in     system clock, all state on the rising edge
//   rst            in     asynchronous, active-high reset
//   addr_i[23:0]   in     byte address from CPU (bit 0 ignored)
//   re_i           in     read strobe, held by the CPU while stalled
//   we_i           in     write strobe, held by the CPU while stalled
//   data_io[15:0]  inout  driven only during a completing in-window read
//   needWait_o     out    stall request to the CPU (combinational)
//
// Optional build macro MEM_BUS_RESPONDER_STATS_EN adds saturating counters:
//   stat_reads_o[15:0]   completed reads
//   stat_writes_o[15:0]  completed writes (re_i&we_i counts as a write)
//   stat_waits_o[15:0]   cycles with needWait_o high
//   stat_aborts_o[7:0]   accesses abandoned while stalled
// -----------------------------------------------------------------------------
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int                    ADDR_BITS   = 10,
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR   = 24'h000000,
  parameter int                    WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_ADDR_W-1:0]   addr_i,
  input  logic                    re_i,
  input  logic                    we_i,
  inout  wire  [BUS_DATA_W-1:0]   data_io,
  output logic                    needWait_o
`ifdef MEM_BUS_RESPONDER_STATS_EN
  ,
  output logic [STAT_W-1:0]       stat_reads_o,
  output logic [STAT_W-1:0]       stat_writes_o,
  output logic [STAT_W-1:0]       stat_waits_o,
  output logic [STAT_ABORT_W-1:0] stat_aborts_o
`endif
);

  // Byte address split: [TAG_LSB +: ...] selects the window, [ADDR_BITS:1]
  // is the word index, bit 0 is the (ignored) byte lane.
  localparam int                    TAG_LSB  = ADDR_BITS + 1;
  localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = wait_load(WAIT_STATES);
  localparam bit                    NO_WAIT  = (WAIT_STATES == 0);

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t                  state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic [BUS_ADDR_W-1:0]   lat_addr;
  bus_op_t                 lat_op;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  bus_op_t               cur_op;
  logic                  req;
  logic                  in_win;
  logic                  hit;
  logic                  same_req;
  logic [ADDR_BITS-1:0]  word_idx;

  assign cur_op   = {re_i, we_i};
  assign req      = re_i | we_i;
  assign in_win   = (addr_i[BUS_ADDR_W-1:TAG_LSB] == BASE_ADDR[BUS_ADDR_W-1:TAG_LSB]);
  assign hit      = req & in_win;
  assign word_idx = addr_i[ADDR_BITS:1];

  // The request in WAIT is the same access only if address and strobes are
  // unchanged; dropping the strobes also shows up as an op mismatch.
  assign same_req = (addr_i == lat_addr) && (cur_op == lat_op);

  // ---------------------------------------------------------------------------
  // Cycle decisions
  //   need_wait : stall the CPU this cycle
  //   complete  : the access finishes this cycle (read drives, write commits)
  //   abort     : the latched access is abandoned this cycle
  //   load      : (re)start a stall for the request on the bus
  // Reset is folded in so an access in flight is dropped the moment rst rises,
  // not at the next edge.
  // ---------------------------------------------------------------------------
  logic need_wait;
  logic complete;
  logic abort;
  logic load;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    need_wait = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    load      = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            if (NO_WAIT) begin
              complete = 1'b1;
            end else begin
              need_wait = 1'b1;
              load      = 1'b1;
            end
          end
        end
        WAIT: begin
          if (!same_req) begin
            // Different address/op, out-of-window move, or strobes dropped.
            abort = 1'b1;
            if (hit) begin
              need_wait = 1'b1;
              load      = 1'b1;
            end
          end else if (cnt != '0) begin
            need_wait = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign needWait_o = need_wait;

  // ---------------------------------------------------------------------------
  // Responder FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_op   <= '0;
    end else if (load) begin
      state    <= WAIT;
      cnt      <= CNT_LOAD;
      lat_addr <= addr_i;
      lat_op   <= cur_op;
    end else if (state == WAIT) begin
      if (complete || abort) begin
        state <= IDLE;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Array and data bus
  // Both strobes high is a write, so the bus is only driven for a pure read.
  // ---------------------------------------------------------------------------
  logic                  wr_done;
  logic                  rd_done;
  logic [BUS_DATA_W-1:0] rdata;

  assign wr_done = complete & we_i;
  assign rd_done = complete & re_i & ~we_i;

  mem_resp_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (BUS_DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_done),
    .waddr (word_idx),
    .wdata (data_io),
    .raddr (word_idx),
    .rdata (rdata)
  );

  assign data_io = rd_done ? rdata : 'z;

  // ---------------------------------------------------------------------------
  // Optional access statistics (saturating, cleared by rst)
  // ---------------------------------------------------------------------------
`ifdef MEM_BUS_RESPONDER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads_o  <= '0;
      stat_writes_o <= '0;
      stat_waits_o  <= '0;
      stat_aborts_o <= '0;
    end else begin
      if (rd_done && !(&stat_reads_o)) begin
        stat_reads_o <= stat_reads_o + 1'b1;
      end
      if (wr_done && !(&stat_writes_o)) begin
        stat_writes_o <= stat_writes_o + 1'b1;
      end
      if (need_wait && !(&stat_waits_o)) begin
        stat_waits_o <= stat_waits_o + 1'b1;
      end
      if (abort && !(&stat_aborts_o)) begin
        stat_aborts_o <= stat_aborts_o + 1'b1;
      end
    end
  end
`endif

endmodule : mem_bus_responder
